alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two
// requesters: accept, one ALU issue cycle, then hold the response until consumed.
module alu_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic signed [15:0] req0_a,
    input  logic signed [15:0] req0_b,
    input  logic signed [15:0] req1_a,
    input  logic signed [15:0] req1_b,
    input  logic [2:0]         req0_op,
    input  logic [2:0]         req1_op,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    input  logic               rsp0_ready,
    input  logic               rsp1_ready,
    output logic [15:0]        rsp_result,
    output logic               rsp_zero,
    output logic               rsp_carry,
    output logic [15:0]        alu_tmp1,
    output logic [15:0]        alu_tmp2,
    output logic [2:0]         alu_op,
    output logic               alu_enable,
    input  logic [15:0]        alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        last_grant;
    logic        grant;
    logic        win;
    logic        accept;
    logic        rsp_hs;
    logic [15:0] tmp1_q;
    logic [15:0] tmp2_q;
    logic [2:0]  op_q;
    logic [15:0] res_q;
    logic        zero_q;
    logic        carry_q;

    // On a tie the requester that was not served last goes next.
    always_comb begin
        win    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept = (state == IDLE) && (req0_valid || req1_valid);
        rsp_hs = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            tmp1_q     <= '0;
            tmp2_q     <= '0;
            op_q       <= '0;
            res_q      <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= win;
                grant      <= win;
                tmp1_q     <= win ? req1_a  : req0_a;
                tmp2_q     <= win ? req1_b  : req0_b;
                op_q       <= win ? req1_op : req0_op;
            end
            if (state == ISSUE) begin
                res_q   <= alu_result;
                zero_q  <= alu_zero;
                carry_q <= alu_carry;
            end
        end
    end

    // Ready is gated by reset so nothing can look accepted while held in reset.
    assign req0_ready = rst_n && accept && !win;
    assign req1_ready = rst_n && accept && win;

    assign alu_enable = (state == ISSUE);
    assign alu_tmp1   = tmp1_q;
    assign alu_tmp2   = tmp2_q;
    assign alu_op     = op_q;

    assign rsp0_valid = (state == RESP) && !grant;
    assign rsp1_valid = (state == RESP) && grant;
    assign rsp_result = res_q;
    assign rsp_zero   = zero_q;
    assign rsp_carry  = carry_q;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a reference ALU sits on the ALU port,
// requests are randomised, and a monitor checks grants and responses.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_carry;
    logic [15:0] alu_tmp1, alu_tmp2;
    logic [2:0]  alu_op;
    logic        alu_enable;
    logic [15:0] alu_result;
    logic        alu_zero, alu_carry;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_last = 1;
    int n0 = 0, n1 = 0;
    bit rnd_en = 0;
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .alu_tmp1(alu_tmp1), .alu_tmp2(alu_tmp2), .alu_op(alu_op),
        .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, zero, result}.
    function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
        logic [16:0] w;
        case (op)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} - {1'b0, b};
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            3'd5:    w = {1'b0, a << b[3:0]};
            3'd6:    w = {1'b0, a >> b[3:0]};
            default: w = {1'b0, b};
        endcase
        return {w[16], w[15:0] == 16'd0, w[15:0]};
    endfunction

    assign {alu_carry, alu_zero, alu_result} = alu_f(alu_tmp1, alu_tmp2, alu_op);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input int n, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
        bit ok = 0;
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if ((n == 0) ? req0_ready : req1_ready) begin
                ok = 1;
                if (n == 0) q0.push_back(alu_f(a, b, op));
                else q1.push_back(alu_f(a, b, op));
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue%0d_timeout: got no ready, expected ready", n);
        end
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic consume(input int n, input int hold);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = (n == 0) ? rsp0_valid : rsp1_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL rsp%0d_timeout: got no valid, expected valid", n);
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", (n == 0) ? rsp0_valid : rsp1_valid, 1);
            chk("hold_busy", busy, 1);
            chk("hold_noaccept", req0_ready | req1_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (n == 0) rsp0_ready = 1'b1;
        else rsp1_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_last = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: grant fairness, response scoreboard, hold stability.
    logic        prev_v0 = 0, prev_v1 = 0, prev_hs0 = 0, prev_hs1 = 0, prev_en = 0;
    logic [17:0] prev_rsp = '0;
    int          w;
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready || req1_ready) begin
                if (req0_valid && req1_valid) w = (model_last == 1) ? 0 : 1;
                else w = req0_valid ? 0 : 1;
                chk("grant", {req1_ready, req0_ready}, (w == 1) ? 2 : 1);
                chk("ready_idle", busy, 0);
                model_last = w;
            end
            if (rsp0_valid && rsp1_valid) chk("rsp_both", 2, 1);
            if (rsp0_valid && !prev_v0) chk("rsp0_expected", q0.size() != 0, 1);
            if (rsp1_valid && !prev_v1) chk("rsp1_expected", q1.size() != 0, 1);
            if ((rsp0_valid && prev_v0 && !prev_hs0) || (rsp1_valid && prev_v1 && !prev_hs1))
                chk("rsp_stable", {rsp_carry, rsp_zero, rsp_result}, prev_rsp);
            if (rsp0_valid && rsp0_ready && q0.size() != 0) begin
                chk("rsp0_data", {rsp_carry, rsp_zero, rsp_result}, q0.pop_front());
                n0++;
            end
            if (rsp1_valid && rsp1_ready && q1.size() != 0) begin
                chk("rsp1_data", {rsp_carry, rsp_zero, rsp_result}, q1.pop_front());
                n1++;
            end
            if (alu_enable) begin
                chk("enable_once", prev_en, 0);
                chk("enable_busy", busy, 1);
            end
        end
        prev_v0  = rsp0_valid;
        prev_v1  = rsp1_valid;
        prev_hs0 = rsp0_valid && rsp0_ready;
        prev_hs1 = rsp1_valid && rsp1_ready;
        prev_en  = alu_enable;
        prev_rsp = {rsp_carry, rsp_zero, rsp_result};
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1;
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        bit drained;
        req0_valid = 1'b1;
        req0_a = 16'h0011;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_enable", alu_enable, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_tmp1", alu_tmp1, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_result", rsp_result, 0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single req0 add, checked cycle by cycle.
        req0_a = 16'hFFFF; req0_b = 16'hFFFE; req0_op = 3'd0; req0_valid = 1'b1;
        @(negedge clk);
        chk("t1_ready0", req0_ready, 1);
        q0.push_back(alu_f(16'hFFFF, 16'hFFFE, 3'd0));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_enable", alu_enable, 1);
        chk("t1_tmp1", alu_tmp1, 16'hFFFF);
        chk("t1_tmp2", alu_tmp2, 16'hFFFE);
        chk("t1_noready", req0_ready, 0);
        @(negedge clk);
        chk("t1_enable_off", alu_enable, 0);
        chk("t1_rsp0", rsp0_valid, 1);
        chk("t1_rsp1", rsp1_valid, 0);
        chk("t1_result", {rsp_carry, rsp_zero, rsp_result}, 18'h2FFFD);
        chk("t1_tmp_hold", alu_tmp1, 16'hFFFF);
        consume(0, 0);

        // Single req1.
        fork
            issue(1, 16'h7FFF, 16'h0002, 3'd0);
            consume(1, 0);
        join
        chk("t2_result", rsp_result, 16'h8001);

        // Tie straight out of reset, then a repeat tie.
        do_reset();
        fork
            issue(0, 16'd3, 16'd2, 3'd0);
            issue(1, 16'd3, 16'hFFFD, 3'd0);
            begin consume(0, 0); consume(1, 0); end
        join
        chk("t3_last", model_last, 1);
        fork
            issue(0, 16'h1234, 16'h00FF, 3'd2);
            issue(1, 16'h1234, 16'h00FF, 3'd4);
            begin consume(0, 0); consume(1, 0); end
        join

        // Backpressure with a waiting req1.
        fork
            issue(0, 16'h8000, 16'h8000, 3'd0);
            begin repeat (2) @(posedge clk); #1; issue(1, 16'h0005, 16'h0007, 3'd1); end
            begin consume(0, 4); consume(1, 0); end
        join

        // Reset during ISSUE drops the operation.
        issue(0, 16'h00AA, 16'h0055, 3'd3);
        chk("t5_enable_pre", alu_enable, 1);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        model_last = 1;
        #1;
        chk("t5_enable_rst", alu_enable, 0);
        chk("t5_busy_rst", busy, 0);
        #2;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_no_rsp", rsp0_valid | rsp1_valid, 0);
        @(posedge clk);
        #1;
        rsp0_ready = 1'b0;
        fork
            issue(0, 16'h0F0F, 16'h0003, 3'd5);
            consume(0, 0);
        join

        // Continuous alternating random traffic.
        s0 = n0;
        s1 = n1;
        rnd_en = 1;
        fork
            for (int i = 0; i < 50; i++)
                issue(0, 16'($urandom), 16'($urandom), 3'($urandom));
            for (int i = 0; i < 50; i++)
                issue(1, 16'($urandom), 16'($urandom), 3'($urandom));
        join
        drained = 0;
        for (int i = 0; i < 400 && !drained; i++) begin
            @(negedge clk);
            drained = (q0.size() == 0) && (q1.size() == 0);
        end
        rnd_en = 0;
        chk("t6_drained", drained, 1);
        chk("t6_count0", n0 - s0, 50);
        chk("t6_count1", n1 - s1, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
